// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Row drive is active-low one-hot; key codes are {row, col}.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef logic [3:0] key_code_t;
  typedef logic [1:0] idx_t;

  function automatic logic [ROWS-1:0] row_drive(input idx_t idx);
    return ~(ROWS'(1) << idx);
  endfunction

endpackage

// File: rtl/module_sync2.sv
// Two-flop synchroniser for asynchronous inputs.
// The reset value lets pulled-up lines start idle.
module module_sync2 #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/module_keypad_scan.sv
// 4x4 active-low keypad scanner with press/release debounce.
// Decisions happen only on the synced clk_div rising-edge tick.
module module_keypad_scan
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_div,
  input  logic [COLS-1:0] col_in,
  output logic [ROWS-1:0] row_out,
  output key_code_t       key_code,
  output logic            key_valid,
  output logic            key_held
);

  localparam logic [3:0] DB_FULL = 4'(DEBOUNCE_TICKS);
  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_TICKS - 1);

  logic            div_s;
  logic            div_prev;
  logic            tick;
  logic [COLS-1:0] col_s;

  module_sync2 #(
    .W       (1),
    .RST_VAL (1'b0)
  ) u_sync_div (
    .clk (clk),
    .rst (rst),
    .d   (clk_div),
    .q   (div_s)
  );

  module_sync2 #(
    .W       (COLS),
    .RST_VAL ({COLS{1'b1}})
  ) u_sync_col (
    .clk (clk),
    .rst (rst),
    .d   (col_in),
    .q   (col_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_prev <= 1'b0;
      tick     <= 1'b0;
    end else begin
      div_prev <= div_s;
      tick     <= div_s & ~div_prev;
    end
  end

  // Column decode: single / none / invalid
  logic [COLS-1:0] low;
  logic            rd_single;
  logic            rd_none;
  idx_t            rd_idx;

  always_comb begin
    low       = ~col_s;
    rd_single = 1'b1;
    rd_none   = 1'b0;
    rd_idx    = 2'd0;
    unique case (low)
      4'b0001: rd_idx = 2'd0;
      4'b0010: rd_idx = 2'd1;
      4'b0100: rd_idx = 2'd2;
      4'b1000: rd_idx = 2'd3;
      default: begin
        rd_single = 1'b0;
        rd_none   = (low == '0);
      end
    endcase
  end

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  idx_t       row_idx, row_n;
  idx_t       col_idx, col_n;
  key_code_t  code_q, code_n;
  logic       valid_q, valid_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SCAN;
      cnt     <= '0;
      row_idx <= '0;
      col_idx <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      row_idx <= row_n;
      col_idx <= col_n;
      code_q  <= code_n;
      valid_q <= valid_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    row_n   = row_idx;
    col_n   = col_idx;
    code_n  = code_q;
    valid_n = 1'b0;
    if (tick) begin
      unique case (state)
        SCAN: begin
          if (rd_single) begin
            col_n   = rd_idx;
            cnt_n   = 4'd1;
            state_n = DEBOUNCE;
          end else begin
            row_n = row_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (rd_single && rd_idx == col_idx) begin
            if (cnt >= DB_LAST) begin
              cnt_n   = DB_FULL;
              code_n  = {row_idx, col_idx};
              valid_n = 1'b1;
              state_n = HELD;
            end else begin
              cnt_n = cnt + 4'd1;
            end
          end else begin
            cnt_n   = '0;
            row_n   = row_idx + 2'd1;
            state_n = SCAN;
          end
        end
        HELD: begin
          if (rd_none) begin
            cnt_n   = 4'd1;
            state_n = RELEASE;
          end
        end
        RELEASE: begin
          if (rd_none) begin
            if (cnt >= DB_LAST) begin
              cnt_n   = '0;
              row_n   = row_idx + 2'd1;
              state_n = SCAN;
            end else begin
              cnt_n = cnt + 4'd1;
            end
          end else begin
            cnt_n   = '0;
            state_n = HELD;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end

  always_comb begin
    row_out   = row_drive(row_idx);
    key_code  = code_q;
    key_valid = valid_q;
    key_held  = (state == HELD) || (state == RELEASE);
  end

endmodule
